// File: rtl/sevseg_scan_ctrl.sv
// Seven-segment digit scanner: runtime-programmable prescaler plus an N-digit anode scan FSM.
// Inserts a blanking gap between digits and skips digits masked off in digit_en_i.
module sevseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned DIV_W            = 16,
  parameter int unsigned DEFAULT_DIV      = 4999,
  parameter int unsigned BLANK_CYC        = 16,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  localparam int unsigned SEL_W           = $clog2(NUM_DIGITS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DIV_W-1:0]      div_val_i,
  input  logic                  div_load_i,
  input  logic [NUM_DIGITS-1:0] digit_en_i,
  output logic                  tick_o,
  output logic                  clk_div_o,
  output logic [SEL_W-1:0]      digit_sel_o,
  output logic [NUM_DIGITS-1:0] anode_o,
  output logic                  blank_o,
  output logic                  frame_done_o
);

  localparam int unsigned BcntW     = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int unsigned BlankLast = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  // Prescaler state
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             clk_div_q, clk_div_d;

  // Scan state
  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic             frame_done_q, frame_done_d;

  logic             wrap;
  logic             apply;
  logic             blank_done;
  logic [SEL_W-1:0] next_sel;
  logic             next_found;
  logic [SEL_W-1:0] low_sel;
  logic [NUM_DIGITS-1:0] anode_act;

  assign wrap       = (cnt_q == div_q);
  // Shadow divisor only lands on a period boundary, or straight away when idle.
  assign apply      = pend_q & (~en_i | wrap);
  assign blank_done = (BLANK_CYC <= 1) || (bcnt_q == BcntW'(BlankLast));

  // Prescaler counter, tick/clk_div generation and divisor shadowing
  always_comb begin
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    clk_div_d = clk_div_q;
    if (en_i) begin
      if (wrap) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_div_d = ~clk_div_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    // A load in the apply cycle stays pending: the old shadow is consumed first.
    shadow_d = div_load_i ? div_val_i : shadow_q;
    pend_d   = div_load_i | (pend_q & ~apply);
    div_d    = apply ? shadow_q : div_q;
  end

  // Circular search from sel_q+1 for the next enabled digit (sel_q itself is the last candidate)
  always_comb begin
    next_sel   = sel_q;
    next_found = 1'b0;
    for (int k = int'(NUM_DIGITS); k >= 1; k--) begin
      int               tmp;
      logic [SEL_W-1:0] idx;
      tmp = int'(sel_q) + k;
      if (tmp >= int'(NUM_DIGITS)) tmp = tmp - int'(NUM_DIGITS);
      idx = SEL_W'(tmp);
      if (digit_en_i[idx]) begin
        next_sel   = idx;
        next_found = 1'b1;
      end
    end
  end

  // Lowest enabled digit, used to seed the scan when leaving idle
  always_comb begin
    low_sel = sel_q;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (digit_en_i[SEL_W'(i)]) low_sel = SEL_W'(i);
    end
  end

  // Scan FSM next-state, digit advance and frame_done
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    bcnt_d       = bcnt_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StBlank;
          bcnt_d  = '0;
          if (|digit_en_i) sel_d = low_sel;
        end
      end
      StBlank: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (!blank_done) begin
          bcnt_d = bcnt_q + BcntW'(1);
        end else if (|digit_en_i) begin
          state_d = StDrive;
          // Digit got masked while blanking: skip forward to an enabled one.
          if (!digit_en_i[sel_q]) sel_d = next_sel;
        end
      end
      StDrive: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (tick_q) begin
          state_d = StBlank;
          bcnt_d  = '0;
          if (next_found) begin
            sel_d        = next_sel;
            frame_done_d = (next_sel <= sel_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All state registers, asynchronously reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      div_q        <= DIV_W'(DEFAULT_DIV);
      shadow_q     <= '0;
      pend_q       <= 1'b0;
      tick_q       <= 1'b0;
      clk_div_q    <= 1'b0;
      state_q      <= StIdle;
      sel_q        <= '0;
      bcnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      tick_q       <= tick_d;
      clk_div_q    <= clk_div_d;
      state_q      <= state_d;
      sel_q        <= sel_d;
      bcnt_q       <= bcnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Anode drive: one-hot only in DRIVE, polarity applied last
  always_comb begin
    anode_act = '0;
    if (state_q == StDrive) anode_act[sel_q] = 1'b1;
    anode_o = ANODE_ACTIVE_LOW ? ~anode_act : anode_act;
  end

  assign blank_o      = (state_q != StDrive);
  assign tick_o       = tick_q;
  assign clk_div_o    = clk_div_q;
  assign digit_sel_o  = sel_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Bench for sevseg_scan_ctrl: two instances (default build and a fast, zero-blank, active-high
// build) run on shared stimulus and are compared every cycle against a behavioural model.
module tb_sevseg_scan_ctrl;

  localparam int Div0   = 4999;
  localparam int Blank0 = 16;
  localparam int Div1   = 3;
  localparam int Blank1 = 0;

  localparam int PhIdle  = 0;
  localparam int PhBlank = 1;
  localparam int PhDrive = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [15:0] div_val = '0;
  logic        div_load = 1'b0;
  logic [3:0]  digit_en = 4'hF;

  logic       tick0, clk_div0, blank0, fd0;
  logic [1:0] sel0;
  logic [3:0] anode0;
  logic       tick1, clk_div1, blank1, fd1;
  logic [1:0] sel1;
  logic [3:0] anode1;

  sevseg_scan_ctrl u_dut0 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .div_val_i   (div_val),
    .div_load_i  (div_load),
    .digit_en_i  (digit_en),
    .tick_o      (tick0),
    .clk_div_o   (clk_div0),
    .digit_sel_o (sel0),
    .anode_o     (anode0),
    .blank_o     (blank0),
    .frame_done_o(fd0)
  );

  sevseg_scan_ctrl #(
    .DEFAULT_DIV     (Div1),
    .BLANK_CYC       (Blank1),
    .ANODE_ACTIVE_LOW(1'b0)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .div_val_i   (div_val),
    .div_load_i  (div_load),
    .digit_en_i  (digit_en),
    .tick_o      (tick1),
    .clk_div_o   (clk_div1),
    .digit_sel_o (sel1),
    .anode_o     (anode1),
    .blank_o     (blank1),
    .frame_done_o(fd1)
  );

  always #5 clk = ~clk;

  // Reference model, one slot per instance
  int m_cnt[2], m_div[2], m_shadow[2], m_sel[2], m_phase[2], m_left[2];
  bit m_pend[2], m_tick[2], m_clkdiv[2], m_fd[2];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic int def_div(input int u);
    return (u == 0) ? Div0 : Div1;
  endfunction

  // Cycles spent blank between digits (a zero setting still costs one cycle in blank)
  function automatic int blank_len(input int u);
    int b;
    b = (u == 0) ? Blank0 : Blank1;
    return (b < 1) ? 1 : b;
  endfunction

  function automatic int next_digit(input int sel, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(sel + k) % 4]) return (sel + k) % 4;
    end
    return -1;
  endfunction

  function automatic int lowest_digit(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_cnt[u] = 0; m_div[u] = def_div(u); m_shadow[u] = 0; m_pend[u] = 0;
      m_tick[u] = 0; m_clkdiv[u] = 0; m_fd[u] = 0;
      m_sel[u] = 0; m_phase[u] = PhIdle; m_left[u] = 0;
    end
  endtask

  task automatic model_step();
    for (int u = 0; u < 2; u++) begin
      bit wrap, apply, old_tick;
      int nxt;
      old_tick = m_tick[u];
      wrap  = (m_cnt[u] == m_div[u]);
      apply = m_pend[u] && (!en || wrap);
      // prescaler
      if (en) begin
        if (wrap) begin
          m_cnt[u] = 0; m_tick[u] = 1; m_clkdiv[u] = !m_clkdiv[u];
        end else begin
          m_cnt[u]++; m_tick[u] = 0;
        end
      end else begin
        m_cnt[u] = 0; m_tick[u] = 0;
      end
      if (apply) m_div[u] = m_shadow[u];
      if (div_load) begin
        m_shadow[u] = int'(div_val); m_pend[u] = 1;
      end else if (apply) begin
        m_pend[u] = 0;
      end
      // scanner
      m_fd[u] = 0;
      if (!en) begin
        m_phase[u] = PhIdle;
      end else if (m_phase[u] == PhIdle) begin
        m_phase[u] = PhBlank;
        m_left[u]  = blank_len(u);
        if (digit_en != 0) m_sel[u] = lowest_digit(digit_en);
      end else if (m_phase[u] == PhBlank) begin
        if (m_left[u] > 1) begin
          m_left[u]--;
        end else if (digit_en != 0) begin
          m_phase[u] = PhDrive;
          if (!digit_en[m_sel[u]]) m_sel[u] = next_digit(m_sel[u], digit_en);
        end
      end else if (old_tick) begin
        m_phase[u] = PhBlank;
        m_left[u]  = blank_len(u);
        nxt = next_digit(m_sel[u], digit_en);
        if (nxt >= 0) begin
          m_fd[u]  = (nxt <= m_sel[u]);
          m_sel[u] = nxt;
        end
      end
    end
  endtask

  task automatic compare();
    for (int u = 0; u < 2; u++) begin
      logic [3:0] oh, an_exp, an_obs;
      logic [9:0] exp, obs;
      oh = (m_phase[u] == PhDrive) ? 4'(1 << m_sel[u]) : 4'h0;
      an_exp = (u == 0) ? ~oh : oh;
      an_obs = (u == 0) ? anode0 : anode1;
      exp = {m_tick[u], m_clkdiv[u], 2'(m_sel[u]), an_exp, m_phase[u] != PhDrive, m_fd[u]};
      obs = (u == 0) ? {tick0, clk_div0, sel0, anode0, blank0, fd0}
                     : {tick1, clk_div1, sel1, anode1, blank1, fd1};
      check_eq($sformatf("u%0d cyc%0d {tick,clkdiv,sel,anode,blank,fdone}", u, cyc),
               32'(obs), 32'(exp));
      check_eq($sformatf("u%0d cyc%0d anodes_asserted<=1", u, cyc),
               32'($countones((u == 0) ? ~an_obs : an_obs) <= 1), 32'd1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic load(input int v);
    div_val  = 16'(v);
    div_load = 1'b1;
    cycle();
    div_load = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    #2 rst_n = 1'b0;
    #1 compare();
    run(3);
    rst_n = 1'b1;
    run(2);

    // Default divider, full frame over all four digits
    en = 1'b1;
    run(21000);

    // Divisor reload mid-period, then back-to-back loads
    guard = 0;
    while (m_cnt[0] != 1000 && guard < 6000) begin
      cycle();
      guard++;
    end
    check_eq("reach_cnt_1000", 32'(guard < 6000), 32'd1);
    load(9);
    run(4100);
    load(9);
    load(19);
    run(80);

    // Digit masks
    digit_en = 4'b0101; run(240);
    digit_en = 4'b0100; run(120);
    digit_en = 4'b0000; run(70);
    digit_en = 4'b1000; run(100);

    // Divisor of zero: tick every cycle
    digit_en = 4'hF;
    load(0);
    run(60);

    // Randomised mix of enable, loads and masks
    repeat (3000) begin
      en       = ($urandom_range(0, 19) != 0);
      div_load = ($urandom_range(0, 15) == 0);
      div_val  = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 24) == 0) digit_en = 4'($urandom);
      cycle();
    end
    div_load = 1'b0;

    // Reset in the middle of a drive, then en 1->0->1
    en = 1'b1;
    digit_en = 4'hF;
    load(5);
    run(30);
    guard = 0;
    while (m_phase[0] != PhDrive && guard < 200) begin
      cycle();
      guard++;
    end
    check_eq("reach_drive", 32'(guard < 200), 32'd1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare();
    run(2);
    rst_n = 1'b1;
    run(30);
    en = 1'b0; run(4);
    en = 1'b1; run(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
